fp_csr: RTL and testbench
=========================

# fp_csr

Floating-point control/status register block for the RV32F datapath. It holds `fflags` (NV, DZ, OF, UF, NX) and `frm`, and accumulates the sticky exception flags reported at writeback by the FP execution units, including the NV flag from the compare unit. It services Zicsr accesses to `fflags`/`frm`/`fcsr` and resolves each FP instruction's rounding mode. It sits beside the FP writeback stage and feeds the FP execute stage.

## Interface

Parameters:
- `WIDTH`, default 32: CSR data width. Only 32 is supported.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `csr_en`, in, 1: a CSR instruction commits this cycle.
- `csr_addr`, in, 12: CSR address. 0x001 = fflags, 0x002 = frm, 0x003 = fcsr.
- `csr_op`, in, 2: 00 none, 01 RW, 10 RS, 11 RC. Immediate variants arrive pre-resolved in `csr_wdata`.
- `csr_wdata`, in, `WIDTH`: operand, either rs1 value or zero-extended zimm.
- `csr_src_zero`, in, 1: rs1 is x0 or zimm is 0. When set, RS and RC perform no write.
- `csr_hit`, out, 1: combinational. Asserted when `csr_addr` is 0x001, 0x002 or 0x003.
- `csr_rdata`, out, `WIDTH`: combinational read value (see Operation).
- `fp_wb_valid`, in, 1: an FP instruction retires this cycle.
- `fp_wb_flags`, in, 5: {NV, DZ, OF, UF, NX} raised by the retiring instruction.
- `inst_rm`, in, 3: rm field of the FP instruction in execute.
- `rm_eff`, out, 3: combinational effective rounding mode.
- `rm_illegal`, out, 1: combinational. The rounding mode is reserved, so the instruction is illegal.
- `fs_dirty`, out, 1: registered one-cycle pulse. FP CSR state was written last cycle.

## Operation

**State**
- `fflags_q[4:0]` and `frm_q[2:0]`.
- fcsr view is {24'd0, frm_q, fflags_q}.

**Flag merge**
- `merged = fflags_q | (fp_wb_valid ? fp_wb_flags : 0)`.
- The retiring FP instruction is older than any CSR instruction committing in the same cycle, so the merge is applied first.

**Read (`csr_rdata`)**
- 0x001: {27'd0, merged}.
- 0x002: {29'd0, frm_q}.
- 0x003: {24'd0, frm_q, merged}.
- Other addresses: 0.
- The bypass through `merged` makes the reads consistent with the merge order.

**Write**
- A write occurs when `csr_en && csr_hit && csr_op != 00`, and not (`csr_op` is RS or RC with `csr_src_zero`).
- new = RW: wdata; RS: old | wdata; RC: old & ~wdata. Here old is the read value before truncation.
- 0x001: `fflags_q <= new[4:0]`; `frm_q` is unchanged.
- 0x002: `frm_q <= new[2:0]`; `fflags_q <= merged`.
- 0x003: `fflags_q <= new[4:0]`, `frm_q <= new[7:5]`.
- Bits [31:8] of `wdata` are ignored. `frm_q` stores any 3-bit value, including 5–7.
- With no write: `fflags_q <= merged`; `frm_q` holds.

**Rounding mode**
- If `inst_rm != 7`: `rm_eff = inst_rm`. Otherwise `rm_eff = frm_q` (the registered value, no bypass of a same-cycle frm write; the hazard unit stalls).
- `rm_illegal = (rm_eff == 5) || (rm_eff == 6) || (rm_eff == 7)`.
- Therefore inst_rm 5/6 are illegal, and dynamic mode is illegal when `frm_q` is 5/6/7.

**fs_dirty**
- Set next cycle when a CSR write occurs, or when `fp_wb_valid` and `merged != fflags_q`.
- Otherwise 0.

## Timing

- Reset (async assert, any cycle): `fflags_q = 0`, `frm_q = 0` (RNE), `fs_dirty = 0`.
- While reset is asserted, combinational outputs reflect the reset state: `csr_rdata` for 0x003 = 0, and `rm_eff = inst_rm` or 0.
- Reset asserted mid-write discards the write. Deassertion is synchronised externally.
- Read latency 0, so the value is valid in the same cycle as `csr_en`.
- Write and flag accumulation become visible one cycle after the edge. The next cycle's `csr_rdata` shows the new value.
- `fs_dirty` trails the causing edge by exactly one cycle and lasts 1 cycle per event. Back-to-back events keep it high.
- Flags are sticky. Only a CSR write to 0x001 or 0x003, or reset, clears them.
- Simultaneous RC on fflags and writeback raising the same flag: the clear wins, because the merge happens before the op.
- `fp_wb_valid` = 0 ignores `fp_wb_flags`, whatever its value.

## Test plan

1. **Reset, then flag accumulation.** Read 0x003, which returns 0x00000000. Then `fp_wb_valid=1`, `flags=10000` (NV from the compare unit on an sNaN). Next-cycle read of 0x001 = 0x10, and `fs_dirty` pulses once.
2. **Sticky accumulation.** Flags 00001, then 00100. Read 0x001 = 0x05. Repeating 00001 leaves the value at 0x05, and `fs_dirty` stays 0.
3. **Simultaneous events.**
   - fflags = 0x05; CSRRC 0x001 with wdata 0x01 in the same cycle as wb flags 00001. Read-old = 0x05, result fflags = 0x04.
   - CSRRW 0x001 with 0 alongside wb flags 10000. Result = 0x00.
4. **fcsr write.** CSRRW 0x003 with wdata 0xFFFFFF8A. Then frm = 4, fflags = 0x0A, and read 0x003 = 0x0000008A. CSRRS with `csr_src_zero=1` and wdata 0xFF leaves the state unchanged and `fs_dirty` = 0.
5. **Rounding mode resolution.**
   - frm = 3, inst_rm = 7: `rm_eff` = 3, legal.
   - inst_rm = 5: illegal.
   - frm written to 6, inst_rm = 7: the following cycle gives `rm_eff` = 6 and `rm_illegal` = 1.
   - inst_rm = 2: `rm_eff` = 2, legal.
6. **Reset mid-operation.** Assert `rst_n=0` asynchronously between edges while a CSRRW 0x003 with 0xE1 is pending. All state reads 0 immediately, and after release the write has not taken effect.

Source files
------------

// File: rtl/fp_csr_if.sv
// Bus between the FP CSR block and the pipeline: Zicsr access, FP writeback flags,
// and rounding-mode resolution for the instruction in execute.
interface fp_csr_if #(
    parameter int WIDTH = 32
);
    logic             csr_en;
    logic [11:0]      csr_addr;
    logic [1:0]       csr_op;
    logic [WIDTH-1:0] csr_wdata;
    logic             csr_src_zero;
    logic             csr_hit;
    logic [WIDTH-1:0] csr_rdata;
    logic             fp_wb_valid;
    logic [4:0]       fp_wb_flags;
    logic [2:0]       inst_rm;
    logic [2:0]       rm_eff;
    logic             rm_illegal;
    logic             fs_dirty;

    modport master (
        output csr_en, csr_addr, csr_op, csr_wdata, csr_src_zero,
               fp_wb_valid, fp_wb_flags, inst_rm,
        input  csr_hit, csr_rdata, rm_eff, rm_illegal, fs_dirty
    );

    modport slave (
        input  csr_en, csr_addr, csr_op, csr_wdata, csr_src_zero,
               fp_wb_valid, fp_wb_flags, inst_rm,
        output csr_hit, csr_rdata, rm_eff, rm_illegal, fs_dirty
    );
endinterface

// File: rtl/fp_csr.sv
// RV32F fflags/frm/fcsr register block: sticky flag accumulation from FP writeback,
// Zicsr read/modify/write, and dynamic rounding-mode resolution.
module fp_csr #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst_n,
    fp_csr_if.slave    bus
);
    localparam logic [11:0] A_FFLAGS = 12'h001;
    localparam logic [11:0] A_FRM    = 12'h002;
    localparam logic [11:0] A_FCSR   = 12'h003;

    logic [4:0]       r_fflags;
    logic [2:0]       r_frm;
    logic             r_fs_dirty;

    logic [4:0]       w_merged;
    logic             w_hit;
    logic [WIDTH-1:0] w_rdata;
    logic             w_wr;
    logic [WIDTH-1:0] w_new;
    logic [4:0]       w_fflags_nxt;
    logic [2:0]       w_frm_nxt;

    // Writeback is older than a same-cycle CSR op, so reads and RMW see merged flags.
    assign w_merged = r_fflags | (bus.fp_wb_valid ? bus.fp_wb_flags : 5'd0);
    assign w_hit    = (bus.csr_addr == A_FFLAGS) || (bus.csr_addr == A_FRM) ||
                      (bus.csr_addr == A_FCSR);

    always_comb begin
        w_rdata = '0;
        case (bus.csr_addr)
            A_FFLAGS: w_rdata = {{(WIDTH-5){1'b0}}, w_merged};
            A_FRM:    w_rdata = {{(WIDTH-3){1'b0}}, r_frm};
            A_FCSR:   w_rdata = {{(WIDTH-8){1'b0}}, r_frm, w_merged};
            default:  w_rdata = '0;
        endcase
    end

    // RS/RC (op[1] set) with a zero source are pure reads.
    assign w_wr = bus.csr_en && w_hit && (bus.csr_op != 2'b00) &&
                  !(bus.csr_op[1] && bus.csr_src_zero);

    always_comb begin
        w_new = bus.csr_wdata;
        case (bus.csr_op)
            2'b10:   w_new = w_rdata | bus.csr_wdata;
            2'b11:   w_new = w_rdata & ~bus.csr_wdata;
            default: w_new = bus.csr_wdata;
        endcase
    end

    always_comb begin
        w_fflags_nxt = w_merged;
        w_frm_nxt    = r_frm;
        if (w_wr) begin
            case (bus.csr_addr)
                A_FFLAGS: w_fflags_nxt = w_new[4:0];
                A_FRM:    w_frm_nxt    = w_new[2:0];
                A_FCSR: begin
                    w_fflags_nxt = w_new[4:0];
                    w_frm_nxt    = w_new[7:5];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fflags   <= 5'd0;
            r_frm      <= 3'd0;
            r_fs_dirty <= 1'b0;
        end else begin
            r_fflags   <= w_fflags_nxt;
            r_frm      <= w_frm_nxt;
            r_fs_dirty <= w_wr || (bus.fp_wb_valid && (w_merged != r_fflags));
        end
    end

    // Dynamic mode uses the registered frm; same-cycle frm writes are stalled upstream.
    assign bus.rm_eff     = (bus.inst_rm != 3'd7) ? bus.inst_rm : r_frm;
    assign bus.rm_illegal = (bus.rm_eff >= 3'd5);
    assign bus.csr_hit    = w_hit;
    assign bus.csr_rdata  = w_rdata;
    assign bus.fs_dirty   = r_fs_dirty;
endmodule

// File: tb/tb_fp_csr.sv
// Randomized and directed bench for fp_csr against a CSR-level reference model.
module tb_fp_csr;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    fp_csr_if #(.WIDTH(32)) bus ();

    fp_csr #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [4:0] m_ff;
    logic [2:0] m_frm;
    logic       m_dirty;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a, input logic [4:0] mf,
                                           input logic [2:0] fr);
        case (a)
            12'h001: return {27'd0, mf};
            12'h002: return {29'd0, fr};
            12'h003: return {24'd0, fr, mf};
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic en, input logic [11:0] a, input logic [1:0] op,
                         input logic [31:0] wd, input logic sz, input logic v,
                         input logic [4:0] f, input logic [2:0] rm);
        bus.csr_en = en; bus.csr_addr = a; bus.csr_op = op; bus.csr_wdata = wd;
        bus.csr_src_zero = sz; bus.fp_wb_valid = v; bus.fp_wb_flags = f; bus.inst_rm = rm;
    endtask

    // One cycle: drive after the falling edge, check outputs, advance the model.
    task automatic step(input logic en, input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] wd, input logic sz, input logic v,
                        input logic [4:0] f, input logic [2:0] rm);
        logic [4:0]  mf;
        logic [31:0] old, nv;
        logic [2:0]  erm;
        logic        hit, wr;
        @(negedge clk);
        drive(en, a, op, wd, sz, v, f, rm);
        #1;
        mf  = m_ff | (v ? f : 5'd0);
        hit = (a == 12'h001) || (a == 12'h002) || (a == 12'h003);
        old = m_read(a, mf, m_frm);
        erm = (rm == 3'd7) ? m_frm : rm;
        chk("hit", {31'd0, bus.csr_hit}, {31'd0, hit});
        chk("rdata", bus.csr_rdata, old);
        chk("rm_eff", {29'd0, bus.rm_eff}, {29'd0, erm});
        chk("rm_illegal", {31'd0, bus.rm_illegal}, {31'd0, (erm inside {3'd5, 3'd6, 3'd7})});
        chk("fs_dirty", {31'd0, bus.fs_dirty}, {31'd0, m_dirty});
        wr = en && hit && (op != 2'b00) && !((op == 2'b10 || op == 2'b11) && sz);
        case (op)
            2'b10:   nv = old | wd;
            2'b11:   nv = old & ~wd;
            default: nv = wd;
        endcase
        m_dirty = wr || (v && (mf != m_ff));
        m_ff = mf;
        if (wr) begin
            if (a == 12'h001 || a == 12'h003) m_ff = nv[4:0];
            if (a == 12'h002) m_frm = nv[2:0];
            if (a == 12'h003) m_frm = nv[7:5];
        end
    endtask

    task automatic rd(input logic [11:0] a, input logic [2:0] rm);
        step(1'b0, a, 2'b00, 32'd0, 1'b0, 1'b0, 5'd0, rm);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        m_ff = 0; m_frm = 0; m_dirty = 0;
        rst_n = 1'b0;
        drive(1'b0, 12'h003, 2'b00, 32'd0, 1'b0, 1'b0, 5'd0, 3'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_fcsr", bus.csr_rdata, 32'd0);
        chk("reset_dirty", {31'd0, bus.fs_dirty}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then NV accumulation
        rd(12'h003, 3'd0);
        chk("tp1_fcsr0", bus.csr_rdata, 32'd0);
        step(1'b0, 12'h000, 2'b00, 32'd0, 1'b0, 1'b1, 5'b10000, 3'd0);
        rd(12'h001, 3'd0);
        chk("tp1_nv", bus.csr_rdata, 32'h10);
        chk("tp1_dirty", {31'd0, bus.fs_dirty}, 32'd1);
        rd(12'h001, 3'd0);
        chk("tp1_dirty_once", {31'd0, bus.fs_dirty}, 32'd0);

        // Sticky accumulation (clear first so the result is 0x05)
        step(1'b1, 12'h001, 2'b01, 32'd0, 1'b0, 1'b0, 5'd0, 3'd0);
        step(1'b0, 12'h000, 2'b00, 32'd0, 1'b0, 1'b1, 5'b00001, 3'd0);
        step(1'b0, 12'h000, 2'b00, 32'd0, 1'b0, 1'b1, 5'b00100, 3'd0);
        rd(12'h001, 3'd0);
        chk("tp2_sticky", bus.csr_rdata, 32'h05);
        step(1'b0, 12'h000, 2'b00, 32'd0, 1'b0, 1'b1, 5'b00001, 3'd0);
        rd(12'h001, 3'd0);
        chk("tp2_repeat", bus.csr_rdata, 32'h05);
        chk("tp2_nodirty", {31'd0, bus.fs_dirty}, 32'd0);

        // RC racing writeback of the same flag: the clear wins
        step(1'b1, 12'h001, 2'b11, 32'h01, 1'b0, 1'b1, 5'b00001, 3'd0);
        chk("tp3_rc_old", bus.csr_rdata, 32'h05);
        rd(12'h001, 3'd0);
        chk("tp3_rc_new", bus.csr_rdata, 32'h04);
        step(1'b1, 12'h001, 2'b01, 32'h0, 1'b0, 1'b1, 5'b10000, 3'd0);
        rd(12'h001, 3'd0);
        chk("tp3_rw_zero", bus.csr_rdata, 32'h00);

        // fcsr write, upper bits ignored; RS with zero source is a pure read
        step(1'b1, 12'h003, 2'b01, 32'hFFFFFF8A, 1'b0, 1'b0, 5'd0, 3'd0);
        rd(12'h003, 3'd0);
        chk("tp4_fcsr", bus.csr_rdata, 32'h8A);
        rd(12'h002, 3'd0);
        chk("tp4_frm", bus.csr_rdata, 32'h4);
        step(1'b1, 12'h003, 2'b10, 32'hFF, 1'b1, 1'b0, 5'd0, 3'd0);
        rd(12'h003, 3'd0);
        chk("tp4_rs_zero", bus.csr_rdata, 32'h8A);
        chk("tp4_rs_nodirty", {31'd0, bus.fs_dirty}, 32'd0);

        // Rounding mode resolution
        step(1'b1, 12'h002, 2'b01, 32'd3, 1'b0, 1'b0, 5'd0, 3'd0);
        rd(12'h000, 3'd7);
        chk("tp5_dyn3", {29'd0, bus.rm_eff}, 32'd3);
        chk("tp5_dyn3_legal", {31'd0, bus.rm_illegal}, 32'd0);
        rd(12'h000, 3'd5);
        chk("tp5_rm5_ill", {31'd0, bus.rm_illegal}, 32'd1);
        step(1'b1, 12'h002, 2'b01, 32'd6, 1'b0, 1'b0, 5'd0, 3'd7);
        chk("tp5_no_bypass", {29'd0, bus.rm_eff}, 32'd3);
        rd(12'h000, 3'd7);
        chk("tp5_dyn6", {29'd0, bus.rm_eff}, 32'd6);
        chk("tp5_dyn6_ill", {31'd0, bus.rm_illegal}, 32'd1);
        rd(12'h000, 3'd2);
        chk("tp5_rm2", {29'd0, bus.rm_eff}, 32'd2);
        chk("tp5_rm2_legal", {31'd0, bus.rm_illegal}, 32'd0);

        // Async reset between edges while an fcsr write is pending
        @(negedge clk);
        drive(1'b1, 12'h003, 2'b01, 32'hE1, 1'b0, 1'b0, 5'd0, 3'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("tp6_fcsr_rst", bus.csr_rdata, 32'd0);
        chk("tp6_rm_rst", {29'd0, bus.rm_eff}, 32'd0);
        chk("tp6_dirty_rst", {31'd0, bus.fs_dirty}, 32'd0);
        m_ff = 0; m_frm = 0; m_dirty = 0;
        @(negedge clk);
        drive(1'b0, 12'h003, 2'b00, 32'd0, 1'b0, 1'b0, 5'd0, 3'd0);
        rst_n = 1'b1;
        rd(12'h003, 3'd7);
        chk("tp6_discarded", bus.csr_rdata, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [11:0] a;
            a = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 4));
            step(($urandom_range(0, 2) != 0), a, 2'($urandom), $urandom,
                 ($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom), 3'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
